// File: rtl/deserializer.sv
// Serial-to-parallel word builder: collects valid bits into DATA_W-bit words, flushing partial words after an idle timeout.
// Optional macro DESER_LSB_FIRST_EN selects LSB-first, right-aligned packing instead of MSB-first, left-aligned.

// state   | meaning
// EMPTY   | no partial word held, bit_cnt == 0
// COLLECT | partial word held, 0 < bit_cnt < DATA_W
module deserializer #(
  parameter int DATA_W       = 16,
  parameter int IDLE_TIMEOUT = 4,
  parameter int MOD_W        = $clog2(DATA_W + 1)
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              ser_data_i,
  input  logic              ser_data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [MOD_W-1:0]  deser_data_mod_o,
  output logic              deser_data_val_o,
  output logic              busy_o
);

  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [MOD_W-1:0]  LAST_POS  = MOD_W'(DATA_W - 1);
  localparam logic [MOD_W-1:0]  FULL_MOD  = MOD_W'(DATA_W);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

  typedef enum logic {EMPTY, COLLECT} state_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  shift_reg, shift_nxt, placed;
  logic [MOD_W-1:0]   bit_cnt, bit_cnt_nxt, pos;
  logic [IDLE_W-1:0]  idle_cnt, idle_nxt;
  logic [DATA_W-1:0]  data_nxt;
  logic [MOD_W-1:0]   mod_nxt;
  logic               val_nxt;

`ifdef DESER_LSB_FIRST_EN
  assign pos = bit_cnt;
`else
  assign pos = LAST_POS - bit_cnt;
`endif

  // Current word with the incoming bit merged at its slot.
  assign placed = shift_reg | (DATA_W'(ser_data_i) << pos);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state            <= EMPTY;
      shift_reg        <= '0;
      bit_cnt          <= '0;
      idle_cnt         <= '0;
      deser_data_o     <= '0;
      deser_data_mod_o <= '0;
      deser_data_val_o <= 1'b0;
    end else begin
      state            <= state_nxt;
      shift_reg        <= shift_nxt;
      bit_cnt          <= bit_cnt_nxt;
      idle_cnt         <= idle_nxt;
      deser_data_o     <= data_nxt;
      deser_data_mod_o <= mod_nxt;
      deser_data_val_o <= val_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_reg;
    bit_cnt_nxt = bit_cnt;
    idle_nxt    = idle_cnt;
    data_nxt    = deser_data_o;
    mod_nxt     = deser_data_mod_o;
    val_nxt     = 1'b0;
    case (state)
      EMPTY: begin
        idle_nxt = '0;
        if (ser_data_val_i) begin
          shift_nxt   = placed;
          bit_cnt_nxt = bit_cnt + 1'b1;
          state_nxt   = COLLECT;
        end
      end
      COLLECT: begin
        if (ser_data_val_i) begin
          idle_nxt = '0;
          if (bit_cnt == LAST_POS) begin
            data_nxt    = placed;
            mod_nxt     = FULL_MOD;
            val_nxt     = 1'b1;
            shift_nxt   = '0;
            bit_cnt_nxt = '0;
            state_nxt   = EMPTY;
          end else begin
            shift_nxt   = placed;
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end else if (idle_cnt == IDLE_LAST) begin
          // This idle cycle brings idle_cnt to the timeout: flush the partial word.
          data_nxt    = shift_reg;
          mod_nxt     = bit_cnt;
          val_nxt     = 1'b1;
          shift_nxt   = '0;
          bit_cnt_nxt = '0;
          idle_nxt    = '0;
          state_nxt   = EMPTY;
        end else begin
          idle_nxt = idle_cnt + 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  assign busy_o = (state == COLLECT);

endmodule

// File: tb/tb_deserializer.sv
// Directed self-checking bench for deserializer (DATA_W=16, IDLE_TIMEOUT=4).
module tb_deserializer;

  logic        clk;
  logic        arst_n;
  logic        ser_data;
  logic        ser_data_val;
  logic [15:0] deser_data;
  logic [4:0]  deser_mod;
  logic        deser_val;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  deserializer #(.DATA_W(16), .IDLE_TIMEOUT(4)) dut (
    .clk_i            (clk),
    .arst_n_i         (arst_n),
    .ser_data_i       (ser_data),
    .ser_data_val_i   (ser_data_val),
    .deser_data_o     (deser_data),
    .deser_data_mod_o (deser_mod),
    .deser_data_val_o (deser_val),
    .busy_o           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of input; return 1 time unit after the sampling edge.
  task automatic cyc(input logic v, input logic b);
    ser_data_val = v;
    ser_data     = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] w;
  logic [15:0] w2;
  logic [9:0]  part;

  initial begin
    arst_n       = 1'b0;
    ser_data     = 1'b0;
    ser_data_val = 1'b0;
    #2;
    check("rst_data", 32'(deser_data), 32'h0);
    check("rst_mod",  32'(deser_mod),  32'h0);
    check("rst_val",  32'(deser_val),  32'h0);
    check("rst_busy", 32'(busy),       32'h0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;

    // Full word A5C3, MSB first
    w = 16'hA5C3;
    for (int i = 15; i >= 1; i--) begin
      cyc(1'b1, w[i]);
      check("full_busy", 32'(busy), 32'h1);
      check("full_noval", 32'(deser_val), 32'h0);
    end
    cyc(1'b1, w[0]);
    check("full_val",  32'(deser_val),  32'h1);
    check("full_data", 32'(deser_data), 32'hA5C3);
    check("full_mod",  32'(deser_mod),  32'd16);
    check("full_busy_pulse", 32'(busy), 32'h0);
    cyc(1'b0, 1'b1);
    check("hold_val",  32'(deser_val),  32'h0);
    check("hold_data", 32'(deser_data), 32'hA5C3);
    check("hold_mod",  32'(deser_mod),  32'd16);

    // Back-to-back words 1234 then FFFF
    w  = 16'h1234;
    w2 = 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, (i < 16) ? w[15-i] : w2[31-i]);
      if (i == 15) begin
        check("b2b_val0",  32'(deser_val),  32'h1);
        check("b2b_data0", 32'(deser_data), 32'h1234);
        check("b2b_mod0",  32'(deser_mod),  32'd16);
      end else if (i == 31) begin
        check("b2b_val1",  32'(deser_val),  32'h1);
        check("b2b_data1", 32'(deser_data), 32'hFFFF);
        check("b2b_mod1",  32'(deser_mod),  32'd16);
      end else begin
        check("b2b_noval", 32'(deser_val), 32'h0);
      end
      if (i == 16) check("b2b_busy_restart", 32'(busy), 32'h1);
    end

    // Partial word 1,0,1,1,0 flushed by timeout
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    check("part_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1);
      check("part_wait_val",  32'(deser_val), 32'h0);
      check("part_wait_busy", 32'(busy),      32'h1);
    end
    cyc(1'b0, 1'b0);
    check("part_val",  32'(deser_val),  32'h1);
    check("part_data", 32'(deser_data), 32'hB000);
    check("part_mod",  32'(deser_mod),  32'd5);
    check("part_busy_pulse", 32'(busy), 32'h0);
    cyc(1'b0, 1'b0);
    check("part_after_val",  32'(deser_val), 32'h0);
    check("part_after_busy", 32'(busy),      32'h0);

    // Bit arriving on the would-be timeout cycle wins
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    check("race_noflush", 32'(deser_val), 32'h0);
    check("race_busy",    32'(busy),      32'h1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0);
      check("race_wait_val", 32'(deser_val), 32'h0);
    end
    cyc(1'b0, 1'b0);
    check("race_val",  32'(deser_val),  32'h1);
    check("race_data", 32'(deser_data), 32'hF000);
    check("race_mod",  32'(deser_mod),  32'd4);

    // Async reset mid-word discards the partial word
    part = 10'b1010101010;
    for (int i = 9; i >= 0; i--) cyc(1'b1, part[i]);
    ser_data_val = 1'b0;
    check("prerst_busy", 32'(busy), 32'h1);
    arst_n = 1'b0;
    #1;
    check("arst_data", 32'(deser_data), 32'h0);
    check("arst_mod",  32'(deser_mod),  32'h0);
    check("arst_val",  32'(deser_val),  32'h0);
    check("arst_busy", 32'(busy),       32'h0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    w = 16'h5A3C;
    for (int i = 15; i >= 1; i--) begin
      cyc(1'b1, w[i]);
      check("postrst_noval", 32'(deser_val), 32'h0);
    end
    cyc(1'b1, w[0]);
    check("postrst_val",  32'(deser_val),  32'h1);
    check("postrst_data", 32'(deser_data), 32'h5A3C);
    check("postrst_mod",  32'(deser_mod),  32'd16);

    // Bits 1,1,0 then timeout
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);
    check("short_val", 32'(deser_val), 32'h1);
`ifdef DESER_LSB_FIRST_EN
    check("short_data", 32'(deser_data), 32'h0003);
`else
    check("short_data", 32'(deser_data), 32'hC000);
`endif
    check("short_mod", 32'(deser_mod), 32'd3);
    cyc(1'b0, 1'b0);
    check("short_after_val", 32'(deser_val), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
